// File: rtl/bcd2421_to_8421_ser.sv
// bcd2421_to_8421_ser: serial digit-by-digit 2421 to 8421 BCD converter with valid/ready handshake
module bcd2421_to_8421_ser #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic [4*DIGITS-1:0] din, res;
    logic [DIGITS-1:0] err;
    logic [3:0] code, dec;
    logic bad, last;
    always_comb begin
        code = din[idx*4 +: 4];
        bad  = code inside {[4'd5:4'd10]};
        dec  = bad ? 4'd0 : code > 4'd4 ? code - 4'd6 : code;
        last = idx == IW'(DIGITS - 1);
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = in_valid ? CONV : IDLE;
            CONV:    state_nxt = last ? DONE : CONV;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // The index stops on the last digit so a held DONE never decodes past the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            din <= '0;
            res <= '0;
            err <= '0;
        end else if (state == IDLE && in_valid) begin
            idx <= '0;
            din <= in_data;
            res <= '0;
            err <= '0;
        end else if (state == CONV) begin
            res[idx*4 +: 4] <= dec;
            err[idx]        <= bad;
            if (!last) idx <= idx + 1'b1;
        end
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = res;
    assign out_err   = err;
endmodule

// File: tb/tb_bcd2421_to_8421_ser.sv
// tb_bcd2421_to_8421_ser: randomized bench against a digit-weight model of the 2421 converter
module tb_bcd2421_to_8421_ser;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [15:0] in_data = '0, out_data;
    logic [3:0] out_err;
    int n_chk = 0, n_fail = 0, cyc = 0, m_age = -1;
    logic [15:0] m_data = '0;
    logic [3:0] m_err = '0;
    logic [15:0] q_data[$];
    logic [3:0] q_err[$];
    int q_cyc[$];

    bcd2421_to_8421_ser #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit value from the 2,4,2,1 weights; only the canonical codes are legal
    function automatic void model_dec(input logic [15:0] w, output logic [15:0] d, output logic [3:0] e);
        d = '0;
        e = '0;
        for (int i = 0; i < D; i++) begin
            int c, v;
            c = int'((w >> (4 * i)) & 16'hF);
            v = 2 * int'(w[4*i+3]) + 4 * int'(w[4*i+2]) + 2 * int'(w[4*i+1]) + int'(w[4*i]);
            if (c >= 5 && c <= 10) e[i] = 1'b1;
            else d = d | 16'(v << (4 * i));
        end
    endfunction

    // m_age: -1 idle, else edges since the accepting edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_in_ready", 32'(in_ready), 1);
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_out_data", 32'(out_data), 0);
            check("rst_out_err", 32'(out_err), 0);
            m_age = -1;
        end else begin
            check("in_ready", 32'(in_ready), 32'(m_age < 0));
            check("out_valid", 32'(out_valid), 32'(m_age >= D));
            if (m_age >= D) begin
                check("out_data", 32'(out_data), 32'(m_data));
                check("out_err", 32'(out_err), 32'(m_err));
                if (out_ready) begin
                    q_data.push_back(out_data);
                    q_err.push_back(out_err);
                    q_cyc.push_back(cyc);
                end
            end
            if (m_age < 0) begin
                if (in_valid) begin
                    m_age = 0;
                    model_dec(in_data, m_data, m_err);
                end
            end else if (m_age < D) m_age++;
            else if (out_ready) m_age = -1;
        end
    end

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data = w;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_data = 16'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_valid: out_valid got 0 expected 1 within 50 cycles at %0t", $time);
        end
    endtask

    task automatic finish_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", 32'(out_valid), 0);
        #1;
    endtask

    initial begin
        int n, visits;
        logic [15:0] d;
        logic [3:0] e;
        model_dec(16'hFE43, d, e);
        check("pin_fe43_d", 32'(d), 32'h9843);
        check("pin_fe43_e", 32'(e), 0);
        model_dec(16'h05A1, d, e);
        check("pin_05a1_d", 32'(d), 32'h0001);
        check("pin_05a1_e", 32'(e), 32'b0110);
        model_dec(16'h1234, d, e);
        check("pin_1234_d", 32'(d), 32'h1234);
        check("pin_1234_e", 32'(e), 0);
        model_dec(16'hBCDE, d, e);
        check("pin_bcde_d", 32'(d), 32'h5678);
        check("pin_bcde_e", 32'(e), 0);
        #1;
        check("init_in_ready", 32'(in_ready), 1);
        check("init_out_valid", 32'(out_valid), 0);
        check("init_out_data", 32'(out_data), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        send(16'hFE43);
        wait_valid(n);
        check("fe43_latency", 32'(n), 4);
        check("fe43_data", 32'(out_data), 32'h9843);
        check("fe43_err", 32'(out_err), 0);
        finish_word();
        send(16'h05A1);
        wait_valid(n);
        check("05a1_latency", 32'(n), 4);
        check("05a1_data", 32'(out_data), 32'h0001);
        check("05a1_err", 32'(out_err), 32'b0110);
        finish_word();
        for (int c = 0; c < 16; c++) begin
            send(16'(c) << (4 * (c % 4)));
            wait_valid(n);
            finish_word();
        end
        out_ready = 1'b0;
        send(16'h0BF3);
        wait_valid(n);
        repeat (5) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'h0593);
            check("hold_err", 32'(out_err), 0);
            check("hold_in_ready", 32'(in_ready), 0);
            in_data = 16'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        finish_word();
        send(16'h7FBA);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_out_data", 32'(out_data), 0);
        check("abort_out_err", 32'(out_err), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(16'h0000);
        wait_valid(n);
        check("zero_latency", 32'(n), 4);
        check("zero_data", 32'(out_data), 0);
        check("zero_err", 32'(out_err), 0);
        finish_word();
        q_data.delete();
        q_err.delete();
        q_cyc.delete();
        in_data = 16'h1234;
        in_valid = 1'b1;
        visits = 0;
        for (int i = 0; i < 40 && visits < 2; i++) begin
            @(posedge clk);
            #2;
            if (in_ready) begin
                visits++;
                if (visits == 1) in_data = 16'hBCDE;
                else in_valid = 1'b0;
            end
        end
        check("seq_visits", 32'(visits), 2);
        check("seq_count", 32'(q_data.size()), 2);
        if (q_data.size() >= 2) begin
            check("seq0_data", 32'(q_data[0]), 32'h1234);
            check("seq0_err", 32'(q_err[0]), 0);
            check("seq1_data", 32'(q_data[1]), 32'h5678);
            check("seq1_err", 32'(q_err[1]), 0);
            check("seq_spacing", 32'(q_cyc[1] - q_cyc[0]), D + 2);
        end
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            rst = ($urandom % 80) == 0;
            in_valid = 1'($urandom);
            in_data = 16'($urandom);
            out_ready = ($urandom % 3) != 0;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
